vending_controller: RTL and testbench

//   Transaction controller for the vending machine. Consumes the purchase strobes
//   (escolher / inserir_dinheiro / dar_troco) and their data from the stimulus source.

---
 rtl/vending_pkg.sv | 38 +++
 rtl/vending_edge_detect.sv | 31 +++
 rtl/vending_controller.sv | 199 +++++++++++++++++++
 tb/tb_vending_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// ============================================================================
// vending_pkg : shared types, widths and price table for the vending machine
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

  localparam int PROD_ID_W = 8;
  localparam int PRICE_W   = 8;
  localparam int MONEY_W_DEFAULT  = 8;
  localparam int WALLET_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_SETTLE   = 2'd2
  } state_t;

  // Prices in cents, indexed by product id - 1
  localparam logic [3:0][PRICE_W-1:0] PRICE_TABLE = {8'd125, 8'd100, 8'd75, 8'd50};

  function automatic logic [PRICE_W-1:0] price_of(input logic [PROD_ID_W-1:0] id);
    logic [PRICE_W-1:0] p;
    p = '0;
    case (id)
      8'd1:    p = PRICE_TABLE[0];
      8'd2:    p = PRICE_TABLE[1];
      8'd3:    p = PRICE_TABLE[2];
      8'd4:    p = PRICE_TABLE[3];
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vending_edge_detect.sv
// ============================================================================
// vending_edge_detect : registered rising-edge detector for one strobe level
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic strobe,
  output logic rise
);

  logic r_prev;
  logic r_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= strobe;
      r_rise <= strobe & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/vending_controller.sv
// ============================================================================
// vending_controller : select -> pay -> settle transaction FSM with wallet
//                      Optional inactivity timeout: VENDING_TIMEOUT_EN
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_controller
  import vending_pkg::*;
#(
  parameter int NUM_PRODUCTS   = 4,
  parameter int MONEY_W        = 8,
  parameter int WALLET_W       = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 escolher,
  input  logic                 inserir_dinheiro,
  input  logic                 dar_troco,
  input  logic [PROD_ID_W-1:0] produto_escolhido,
  input  logic [MONEY_W-1:0]   dinheiro_inserido,
  output logic                 liberar_produto,
  output logic [PROD_ID_W-1:0] produto_liberado,
  output logic [MONEY_W-1:0]   troco,
  output logic                 troco_valido,
  output logic [WALLET_W-1:0]  carteira,
  output logic                 erro,
  output logic [1:0]           estado
);

  localparam int c_esc = 0;
  localparam int c_ins = 1;
  localparam int c_dar = 2;

  logic [2:0] w_strobe;
  logic [2:0] w_edge;

  assign w_strobe = {dar_troco, inserir_dinheiro, escolher};

  for (genvar g = 0; g < 3; g++) begin : g_edge
    vending_edge_detect u_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .strobe  (w_strobe[g]),
      .rise    (w_edge[g])
    );
  end

  state_t               r_state, w_state_nx;
  logic [PROD_ID_W-1:0] r_prod_q, r_id, w_id_nx, r_prod_lib, w_prod_lib_nx;
  logic [MONEY_W-1:0]   r_din_q, r_credit, w_credit_nx, r_price, w_price_nx;
  logic [MONEY_W-1:0]   r_troco, w_troco_nx, w_price_sel;
  logic [WALLET_W-1:0]  r_carteira, w_carteira_nx;
  logic                 r_liberar, w_liberar_nx, r_troco_valido, w_troco_valido_nx;
  logic                 r_erro, w_erro_nx, r_timeout, w_timeout_nx;
  logic                 w_accept, w_timeout_hit, w_id_valid;
  logic [MONEY_W:0]     w_sum;
  logic [WALLET_W:0]    w_wsum;

  assign w_price_sel = MONEY_W'(price_of(r_prod_q));
  assign w_id_valid  = (r_prod_q != '0) && (int'(r_prod_q) <= NUM_PRODUCTS);
  assign w_sum       = {1'b0, r_credit} + {1'b0, r_din_q};
  assign w_wsum      = {1'b0, r_carteira} + (WALLET_W + 1)'(r_price);

`ifdef VENDING_TIMEOUT_EN
  localparam int c_tcnt_w = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_tcnt_w-1:0] r_tcnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                r_tcnt <= '0;
    else if (r_state != ST_SELECTED || w_accept) r_tcnt <= '0;
    else                                         r_tcnt <= r_tcnt + c_tcnt_w'(1);
  end

  assign w_timeout_hit = (r_state == ST_SELECTED) &&
                         (r_tcnt == c_tcnt_w'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_prod_q       <= '0;
      r_din_q        <= '0;
      r_id           <= '0;
      r_price        <= '0;
      r_credit       <= '0;
      r_troco        <= '0;
      r_prod_lib     <= '0;
      r_carteira     <= '0;
      r_liberar      <= 1'b0;
      r_troco_valido <= 1'b0;
      r_erro         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      // Data delayed to line up with the registered edge pulses
      r_prod_q       <= produto_escolhido;
      r_din_q        <= dinheiro_inserido;
      r_id           <= w_id_nx;
      r_price        <= w_price_nx;
      r_credit       <= w_credit_nx;
      r_troco        <= w_troco_nx;
      r_prod_lib     <= w_prod_lib_nx;
      r_carteira     <= w_carteira_nx;
      r_liberar      <= w_liberar_nx;
      r_troco_valido <= w_troco_valido_nx;
      r_erro         <= w_erro_nx;
      r_timeout      <= w_timeout_nx;
    end
  end

  always_comb begin
    w_state_nx        = r_state;
    w_id_nx           = r_id;
    w_price_nx        = r_price;
    w_credit_nx       = r_credit;
    w_troco_nx        = r_troco;
    w_prod_lib_nx     = r_prod_lib;
    w_carteira_nx     = r_carteira;
    w_liberar_nx      = 1'b0;
    w_troco_valido_nx = 1'b0;
    w_erro_nx         = 1'b0;
    w_timeout_nx      = r_timeout;
    w_accept          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_edge[c_esc]) begin
          if (w_id_valid) begin
            w_id_nx      = r_prod_q;
            w_price_nx   = w_price_sel;
            w_credit_nx  = '0;
            w_timeout_nx = 1'b0;
            w_state_nx   = ST_SELECTED;
          end else begin
            w_erro_nx = 1'b1;
          end
        end
      end

      ST_SELECTED: begin
        if (w_edge[c_dar]) begin
          w_accept   = 1'b1;
          w_state_nx = ST_SETTLE;
        end else if (w_edge[c_ins]) begin
          w_accept = 1'b1;
          if (w_sum[MONEY_W]) w_erro_nx   = 1'b1;
          else                w_credit_nx = w_sum[MONEY_W-1:0];
        end else if (w_edge[c_esc]) begin
          // Reselection only before any money has been taken
          if (r_credit == '0) begin
            w_accept = 1'b1;
            if (w_id_valid) begin
              w_id_nx    = r_prod_q;
              w_price_nx = w_price_sel;
            end else begin
              w_erro_nx = 1'b1;
            end
          end
        end else if (w_timeout_hit) begin
          w_timeout_nx = 1'b1;
          w_state_nx   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (!r_timeout && (r_credit >= r_price)) begin
          w_troco_nx    = r_credit - r_price;
          w_liberar_nx  = 1'b1;
          w_prod_lib_nx = r_id;
          w_carteira_nx = w_wsum[WALLET_W] ? {WALLET_W{1'b1}} : w_wsum[WALLET_W-1:0];
        end else begin
          w_troco_nx = r_credit;
          w_erro_nx  = 1'b1;
        end
        w_troco_valido_nx = 1'b1;
        w_credit_nx       = '0;
        w_timeout_nx      = 1'b0;
        w_state_nx        = ST_IDLE;
      end

      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign liberar_produto  = r_liberar;
  assign produto_liberado = r_prod_lib;
  assign troco            = r_troco;
  assign troco_valido     = r_troco_valido;
  assign carteira         = r_carteira;
  assign erro             = r_erro;
  assign estado           = r_state;

endmodule

`default_nettype wire

// File: tb/tb_vending_controller.sv
// ============================================================================
// tb_vending_controller : directed self-checking bench for vending_controller
// Revision              : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vending_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        escolher = 1'b0;
  logic        inserir_dinheiro = 1'b0;
  logic        dar_troco = 1'b0;
  logic [7:0]  produto_escolhido = '0;
  logic [7:0]  dinheiro_inserido = '0;
  logic        liberar_produto;
  logic [7:0]  produto_liberado;
  logic [7:0]  troco;
  logic        troco_valido;
  logic [15:0] carteira;
  logic        erro;
  logic [1:0]  estado;

  int n_vec = 0;
  int n_err = 0;
  int n_lib = 0;
  int n_tv  = 0;
  int n_erro = 0;
  int s_lib, s_tv, s_erro;

  always #5 clock = ~clock;

  vending_controller dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .escolher          (escolher),
    .inserir_dinheiro  (inserir_dinheiro),
    .dar_troco         (dar_troco),
    .produto_escolhido (produto_escolhido),
    .dinheiro_inserido (dinheiro_inserido),
    .liberar_produto   (liberar_produto),
    .produto_liberado  (produto_liberado),
    .troco             (troco),
    .troco_valido      (troco_valido),
    .carteira          (carteira),
    .erro              (erro),
    .estado            (estado)
  );

  // Pulse counters sampled mid-cycle
  always @(negedge clock) begin
    if (liberar_produto) n_lib++;
    if (troco_valido)    n_tv++;
    if (erro)            n_erro++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic snap();
    s_lib = n_lib; s_tv = n_tv; s_erro = n_erro;
  endtask

  task automatic do_esc(input logic [7:0] id, input int hold);
    produto_escolhido = id;
    escolher = 1'b1;
    idle(hold);
    escolher = 1'b0;
    idle(4);
  endtask

  task automatic do_ins(input logic [7:0] amt);
    dinheiro_inserido = amt;
    inserir_dinheiro = 1'b1;
    idle(2);
    inserir_dinheiro = 1'b0;
    idle(4);
  endtask

  task automatic do_dar();
    dar_troco = 1'b1;
    idle(2);
    dar_troco = 1'b0;
    idle(4);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(2);
    n_vec++; if (liberar_produto !== 1'b0) begin n_err++; $display("FAIL rst_liberar: got %0d, expected 0", liberar_produto); end
    n_vec++; if (produto_liberado !== 8'd0) begin n_err++; $display("FAIL rst_prod: got %0d, expected 0", produto_liberado); end
    n_vec++; if (troco !== 8'd0) begin n_err++; $display("FAIL rst_troco: got %0d, expected 0", troco); end
    n_vec++; if (troco_valido !== 1'b0) begin n_err++; $display("FAIL rst_tv: got %0d, expected 0", troco_valido); end
    n_vec++; if (carteira !== 16'd0) begin n_err++; $display("FAIL rst_carteira: got %0d, expected 0", carteira); end
    n_vec++; if (erro !== 1'b0) begin n_err++; $display("FAIL rst_erro: got %0d, expected 0", erro); end
    n_vec++; if (estado !== 2'd0) begin n_err++; $display("FAIL rst_estado: got %0d, expected 0", estado); end
  endtask

  task automatic test_dispense();
    snap();
    do_esc(8'd1, 2);
    n_vec++; if (estado !== 2'd1) begin n_err++; $display("FAIL t1_selected: got %0d, expected 1", estado); end
    do_ins(8'd150);
    do_dar();
    n_vec++; if (n_lib - s_lib !== 1) begin n_err++; $display("FAIL t1_lib_pulses: got %0d, expected 1", n_lib - s_lib); end
    n_vec++; if (produto_liberado !== 8'd1) begin n_err++; $display("FAIL t1_prod: got %0d, expected 1", produto_liberado); end
    n_vec++; if (troco !== 8'd100) begin n_err++; $display("FAIL t1_troco: got %0d, expected 100", troco); end
    n_vec++; if (n_tv - s_tv !== 1) begin n_err++; $display("FAIL t1_tv_pulses: got %0d, expected 1", n_tv - s_tv); end
    n_vec++; if (carteira !== 16'd50) begin n_err++; $display("FAIL t1_carteira: got %0d, expected 50", carteira); end
    n_vec++; if (n_erro - s_erro !== 0) begin n_err++; $display("FAIL t1_erro: got %0d, expected 0", n_erro - s_erro); end
    n_vec++; if (estado !== 2'd0) begin n_err++; $display("FAIL t1_estado: got %0d, expected 0", estado); end
  endtask

  task automatic test_second();
    do_esc(8'd2, 2);
    do_ins(8'd100);
    do_dar();
    n_vec++; if (troco !== 8'd25) begin n_err++; $display("FAIL t2_troco: got %0d, expected 25", troco); end
    n_vec++; if (carteira !== 16'd125) begin n_err++; $display("FAIL t2_carteira: got %0d, expected 125", carteira); end
    n_vec++; if (produto_liberado !== 8'd2) begin n_err++; $display("FAIL t2_prod: got %0d, expected 2", produto_liberado); end
  endtask

  task automatic test_underpay();
    snap();
    do_esc(8'd2, 2);
    do_ins(8'd50);
    do_dar();
    n_vec++; if (n_lib - s_lib !== 0) begin n_err++; $display("FAIL t3_lib_pulses: got %0d, expected 0", n_lib - s_lib); end
    n_vec++; if (troco !== 8'd50) begin n_err++; $display("FAIL t3_troco: got %0d, expected 50", troco); end
    n_vec++; if (n_erro - s_erro !== 1) begin n_err++; $display("FAIL t3_erro: got %0d, expected 1", n_erro - s_erro); end
    n_vec++; if (n_tv - s_tv !== 1) begin n_err++; $display("FAIL t3_tv: got %0d, expected 1", n_tv - s_tv); end
    n_vec++; if (carteira !== 16'd125) begin n_err++; $display("FAIL t3_carteira: got %0d, expected 125", carteira); end
  endtask

  task automatic test_invalid();
    snap();
    do_esc(8'd0, 2);
    n_vec++; if (n_erro - s_erro !== 1) begin n_err++; $display("FAIL t4_erro_id0: got %0d, expected 1", n_erro - s_erro); end
    n_vec++; if (estado !== 2'd0) begin n_err++; $display("FAIL t4_estado_id0: got %0d, expected 0", estado); end
    do_esc(8'd9, 2);
    n_vec++; if (n_erro - s_erro !== 2) begin n_err++; $display("FAIL t4_erro_id9: got %0d, expected 2", n_erro - s_erro); end
    n_vec++; if (estado !== 2'd0) begin n_err++; $display("FAIL t4_estado_id9: got %0d, expected 0", estado); end
    do_ins(8'd100);
    do_dar();
    n_vec++; if (n_erro - s_erro !== 2) begin n_err++; $display("FAIL t4_idle_ins_erro: got %0d, expected 2", n_erro - s_erro); end
    n_vec++; if (n_tv - s_tv !== 0) begin n_err++; $display("FAIL t4_idle_tv: got %0d, expected 0", n_tv - s_tv); end
    n_vec++; if (estado !== 2'd0) begin n_err++; $display("FAIL t4_idle_estado: got %0d, expected 0", estado); end
  endtask

  task automatic test_overflow();
    snap();
    do_esc(8'd3, 2);
    do_ins(8'd200);
    do_ins(8'd100);
    n_vec++; if (n_erro - s_erro !== 1) begin n_err++; $display("FAIL t5_ovf_erro: got %0d, expected 1", n_erro - s_erro); end
    do_dar();
    n_vec++; if (troco !== 8'd100) begin n_err++; $display("FAIL t5_troco: got %0d, expected 100", troco); end
    n_vec++; if (carteira !== 16'd225) begin n_err++; $display("FAIL t5_carteira: got %0d, expected 225", carteira); end
    n_vec++; if (n_lib - s_lib !== 1) begin n_err++; $display("FAIL t5_lib: got %0d, expected 1", n_lib - s_lib); end
  endtask

  // Held escolher: the id changes to an invalid one mid-hold, which must not retrigger
  task automatic test_hold();
    snap();
    produto_escolhido = 8'd1;
    escolher = 1'b1;
    idle(1);
    produto_escolhido = 8'd9;
    idle(4);
    escolher = 1'b0;
    idle(4);
    n_vec++; if (n_erro - s_erro !== 0) begin n_err++; $display("FAIL hold_erro: got %0d, expected 0", n_erro - s_erro); end
    n_vec++; if (estado !== 2'd1) begin n_err++; $display("FAIL hold_estado: got %0d, expected 1", estado); end
    do_ins(8'd50);
    do_dar();
    n_vec++; if (produto_liberado !== 8'd1) begin n_err++; $display("FAIL hold_prod: got %0d, expected 1", produto_liberado); end
    n_vec++; if (troco !== 8'd0) begin n_err++; $display("FAIL hold_troco: got %0d, expected 0", troco); end
    n_vec++; if (carteira !== 16'd275) begin n_err++; $display("FAIL hold_carteira: got %0d, expected 275", carteira); end
  endtask

  task automatic test_priority();
    snap();
    do_esc(8'd4, 2);
    do_ins(8'd100);
    dinheiro_inserido = 8'd100;
    inserir_dinheiro = 1'b1;
    dar_troco = 1'b1;
    idle(2);
    inserir_dinheiro = 1'b0;
    dar_troco = 1'b0;
    idle(4);
    n_vec++; if (troco !== 8'd100) begin n_err++; $display("FAIL prio_troco: got %0d, expected 100", troco); end
    n_vec++; if (n_lib - s_lib !== 0) begin n_err++; $display("FAIL prio_lib: got %0d, expected 0", n_lib - s_lib); end
    n_vec++; if (carteira !== 16'd275) begin n_err++; $display("FAIL prio_carteira: got %0d, expected 275", carteira); end
    n_vec++; if (estado !== 2'd0) begin n_err++; $display("FAIL prio_estado: got %0d, expected 0", estado); end
  endtask

  task automatic test_reselect();
    do_esc(8'd1, 2);
    do_esc(8'd4, 2);
    do_ins(8'd125);
    do_dar();
    n_vec++; if (produto_liberado !== 8'd4) begin n_err++; $display("FAIL resel_prod: got %0d, expected 4", produto_liberado); end
    n_vec++; if (carteira !== 16'd400) begin n_err++; $display("FAIL resel_carteira: got %0d, expected 400", carteira); end
    do_esc(8'd1, 2);
    do_ins(8'd50);
    do_esc(8'd4, 2);
    do_dar();
    n_vec++; if (produto_liberado !== 8'd1) begin n_err++; $display("FAIL nosel_prod: got %0d, expected 1", produto_liberado); end
    n_vec++; if (troco !== 8'd0) begin n_err++; $display("FAIL nosel_troco: got %0d, expected 0", troco); end
    n_vec++; if (carteira !== 16'd450) begin n_err++; $display("FAIL nosel_carteira: got %0d, expected 450", carteira); end
  endtask

  task automatic test_timeout();
    snap();
    do_esc(8'd1, 2);
    do_ins(8'd25);
`ifdef VENDING_TIMEOUT_EN
    idle(70);
    n_vec++; if (troco !== 8'd25) begin n_err++; $display("FAIL to_troco: got %0d, expected 25", troco); end
    n_vec++; if (n_erro - s_erro !== 1) begin n_err++; $display("FAIL to_erro: got %0d, expected 1", n_erro - s_erro); end
    n_vec++; if (n_tv - s_tv !== 1) begin n_err++; $display("FAIL to_tv: got %0d, expected 1", n_tv - s_tv); end
    n_vec++; if (n_lib - s_lib !== 0) begin n_err++; $display("FAIL to_lib: got %0d, expected 0", n_lib - s_lib); end
    n_vec++; if (estado !== 2'd0) begin n_err++; $display("FAIL to_estado: got %0d, expected 0", estado); end
`else
    idle(80);
    n_vec++; if (estado !== 2'd1) begin n_err++; $display("FAIL noto_estado: got %0d, expected 1", estado); end
    n_vec++; if (n_tv - s_tv !== 0) begin n_err++; $display("FAIL noto_tv: got %0d, expected 0", n_tv - s_tv); end
    do_dar();
    n_vec++; if (troco !== 8'd25) begin n_err++; $display("FAIL noto_troco: got %0d, expected 25", troco); end
`endif
    n_vec++; if (carteira !== 16'd450) begin n_err++; $display("FAIL to_carteira: got %0d, expected 450", carteira); end
  endtask

  task automatic test_reset_mid();
    do_esc(8'd1, 2);
    do_ins(8'd50);
    reset_n = 1'b0;
    #1;
    n_vec++; if (estado !== 2'd0) begin n_err++; $display("FAIL rmid_estado: got %0d, expected 0", estado); end
    n_vec++; if (carteira !== 16'd0) begin n_err++; $display("FAIL rmid_carteira: got %0d, expected 0", carteira); end
    n_vec++; if (troco !== 8'd0) begin n_err++; $display("FAIL rmid_troco: got %0d, expected 0", troco); end
    n_vec++; if (produto_liberado !== 8'd0) begin n_err++; $display("FAIL rmid_prod: got %0d, expected 0", produto_liberado); end
    idle(2);
    reset_n = 1'b1;
    idle(2);
    snap();
    do_dar();
    n_vec++; if (n_tv - s_tv !== 0) begin n_err++; $display("FAIL rmid_dar_ignored: got %0d, expected 0", n_tv - s_tv); end
    chk("rmid_estado_after", int'(estado), 0);
  endtask

  initial begin
    idle(1);
    test_reset();
    test_dispense();
    test_second();
    test_underpay();
    test_invalid();
    test_overflow();
    test_hold();
    test_priority();
    test_reselect();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
